main_function_arbiter: RTL

//   Round-robin arbiter/sequencer sharing one multi-cycle main_function unit among N requesters.

---
 rtl/main_function_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/main_function_arbiter.sv
// ---------------------------------------------------------------------------
// main_function_arbiter
//
// Purpose:
//   Shares one multi-cycle main_function unit between N requesters using a
//   round-robin arbiter. The winner's operands are registered and sent to the
//   unit, the arbiter sends a one-cycle start, follows the unit's busy
//   handshake, latches the 24-bit result and pulses done to the owner. If the
//   unit never raises busy, a sticky error is set and the operation is closed
//   with a zero result, so the arbiter never hangs.
//
// Ports:
//   clk_i         in   1      clock, rising edge
//   rst_i         in   1      asynchronous reset, active low
//   req_i         in   N      level request per requester
//   a_bi, b_bi    in   8*N    operands, requester k at [8k+7:8k]
//   grant_o       out  N      one-hot current owner
//   done_o        out  N      one-cycle completion pulse to the owner
//   result_bo     out  24     last completed result, held until next done
//   err_o         out  1      sticky busy-timeout error
//   fu_start_o    out  1      start pulse to main_function
//   fu_a_bo       out  8      registered operand a to main_function
//   fu_b_bo       out  8      registered operand b to main_function
//   fu_busy_i     in   1      busy from main_function
//   fu_result_bi  in   24     result from main_function
// ---------------------------------------------------------------------------
module main_function_arbiter #(
    parameter int N            = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic [8*N-1:0]   a_bi,
    input  logic [8*N-1:0]   b_bi,
    output logic [N-1:0]     grant_o,
    output logic [N-1:0]     done_o,
    output logic [23:0]      result_bo,
    output logic             err_o,
    output logic             fu_start_o,
    output logic [7:0]       fu_a_bo,
    output logic [7:0]       fu_b_bo,
    input  logic             fu_busy_i,
    input  logic [23:0]      fu_result_bi
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [7:0]      fu_a_q, fu_a_d;
    logic [7:0]      fu_b_q, fu_b_d;
    logic [23:0]     result_q, result_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            found;
    logic [PW-1:0]   winner;
    logic [PW:0]     idx;

    // Round-robin search: scan from the requester after the last winner,
    // wrapping around, so the last winner ends up with lowest priority.
    // idx is one bit wider than the pointer so ptr+N never overflows.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req_i[idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

    // Next-state logic. Operands and grant are captured only on leaving IDLE
    // so they stay frozen for the whole operation regardless of the inputs.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        fu_a_d   = fu_a_q;
        fu_b_d   = fu_b_q;
        result_d = result_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = N'(1) << winner;
                    fu_a_d  = a_bi[8*winner +: 8];
                    fu_b_d  = b_bi[8*winner +: 8];
                    ptr_d   = winner;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                // Give up after BUSY_TIMEOUT cycles without busy; close the
                // operation with a zero result rather than wait forever.
                if (fu_busy_i) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_LO: begin
                if (!fu_busy_i) begin
                    result_d = fu_result_bi;
                    state_d  = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. The pointer resets to N-1 so requester 0 wins the
    // first arbitration.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= PW'(N - 1);
            grant_q  <= '0;
            fu_a_q   <= '0;
            fu_b_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            fu_a_q   <= fu_a_d;
            fu_b_q   <= fu_b_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Done is suppressed when the owner has already withdrawn its request.
    assign done_o     = (state_q == DONE) ? (grant_q & req_i) : '0;
    assign fu_start_o = (state_q == START);
    assign grant_o    = grant_q;
    assign result_bo  = result_q;
    assign err_o      = err_q;
    assign fu_a_bo    = fu_a_q;
    assign fu_b_bo    = fu_b_q;

endmodule
